ex_mdu: RTL and testbench
=========================

Name: ex_mdu

Overview:
Parametrised multi-cycle multiply/divide unit that sits beside the single-cycle ALU in the EX stage.
- Replaces the combinational `*` path with an iterative shift-add multiplier and a restoring divider.
- Adds high-half multiply, signed/unsigned divide and remainder.
- Uses valid/ready handshakes on both sides so the EX controller can stall on `busy_o` and hold EX-over low until `out_valid_o`.

Parameters:
- XLEN, 32: operand/result width.
- MUL_STEP, 2: multiplier bits retired per cycle. Legal values are 1, 2, 4; XLEN % MUL_STEP must be 0.
- TAG_W, 5: width of the tag carried with the op (destination register address).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- flush_i  in  1  kill the in-flight op. Synchronous; overrides all other inputs except rst_i.
- in_valid_i  in  1  op request.
- in_ready_o  out  1  unit can accept an op (state IDLE and not rst_i).
- op_i  in  3  opcode: 0 MUL, 1 MULH, 2 MULHU, 3 DIV, 4 DIVU, 5 MOD, 6 MODU, 7 reserved.
- opd1_i  in  XLEN  rj (multiplicand/dividend).
- opd2_i  in  XLEN  rk (multiplier/divisor).
- tag_i  in  TAG_W  destination tag.
- out_valid_o  out  1  result available.
- out_ready_i  in  1  consumer takes result.
- result_o  out  XLEN  result.
- tag_o  out  TAG_W  tag of the result.
- busy_o  out  1  op accepted and result not yet consumed.

Behaviour:
- Reset state: IDLE.
  - out_valid_o=0, busy_o=0, result_o=0, tag_o=0.
  - in_ready_o=0 while rst_i is high, then 1 from the first cycle after reset.
- States: IDLE, CALC, FIX, DONE.
- Accept: at the rising edge where in_valid_i & in_ready_o & ~flush_i.
  - Latch op, tag, operand signs and operand magnitudes. Signed ops (MUL, MULH, DIV, MOD) take two's-complement absolute values; the |INT_MIN| = 2^(XLEN-1) unsigned encoding is valid.
  - Load the counter.
  - Next state: CALC, except divisor==0 with op 3–6 or op==7, which go straight to FIX.
- CALC, multiply:
  - Each cycle adds (multiplicand << i) × (MUL_STEP multiplier bits) into a 2·XLEN accumulator.
  - Lasts XLEN/MUL_STEP cycles.
- CALC, divide: restoring division, 1 quotient bit per cycle, XLEN cycles. Uses an XLEN+1-bit partial remainder.
- FIX (1 cycle):
  - MUL, MULH: negate the 2·XLEN product if the signs differ. MUL returns product[XLEN-1:0]; MULH and MULHU return product[2XLEN-1:XLEN].
  - DIV: negate the quotient if sign1^sign2.
  - MOD: negate the remainder if sign1.
  - Divide by zero: DIV/DIVU return all-ones; MOD/MODU return opd1 unchanged.
  - op 7 returns 0.
  - Overflow INT_MIN/-1 falls out naturally: quotient = INT_MIN, remainder = 0.
- DONE:
  - out_valid_o=1; result_o and tag_o are held stable until out_valid_o & out_ready_i.
  - The handshake returns the unit to IDLE on the next edge. No same-cycle re-accept: max throughput is one op per (latency+1) cycles.
- Latency, counting the accept edge as cycle 0 (out_valid_o first high at):
  - MUL/MULH/MULHU: cycle XLEN/MUL_STEP+2.
  - Div/mod: cycle XLEN+2.
  - Div-by-zero and op 7: cycle 2.
- busy_o = (state != IDLE).
- Flush:
  - Any non-IDLE state goes to IDLE at the next edge; out_valid_o=0 from that cycle.
  - The result is discarded and no handshake is needed.
  - flush_i in IDLE blocks the accept in that same cycle.
- rst_i mid-operation: identical to flush, and also zeroes result_o and tag_o.
- in_valid_i while busy: ignored; the requester must hold it.
- Operand inputs are only sampled at accept; they may change afterwards.

Test Plan (XLEN=32, MUL_STEP=2):
1. MUL 7 × 0xFFFFFFFD, tag 5 -> result 0xFFFFFFEB, tag_o 5, out_valid_o first high at cycle 18.
   MULH 0x80000000×0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
2. DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD at cycle 34. MOD same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. MODU 100/7 -> 2.
3. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. MOD same operands -> 0.
   DIVU 5/0 -> 0xFFFFFFFF at cycle 2. MOD 0x1234/0 -> 0x1234.
4. Backpressure: hold out_ready_i=0 for 5 cycles after out_valid_o -> result and tag stable, busy_o=1, in_ready_o=0, in_valid_i ignored.
   Raise out_ready_i -> IDLE next cycle, then the next op is accepted.
5. flush_i at cycle 10 of a DIV -> out_valid_o never asserts, in_ready_o=1 the following cycle.
   The new MUL 3×4 then returns 12 with the correct tag.
6. rst_i pulsed during CALC -> all outputs 0 the next cycle, in_ready_o=1 one cycle after rst_i drops.

Source files
------------

// File: rtl/ex_mdu.sv
// Iterative multiply/divide unit for the EX stage: shift-add multiplier retiring
// MUL_STEP bits per cycle and a restoring divider, with valid/ready on both sides.
module ex_mdu #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 2,
    parameter int TAG_W    = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [2:0]       op_i,
    input  logic [XLEN-1:0]  opd1_i,
    input  logic [XLEN-1:0]  opd2_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  result_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             busy_o
);
    localparam int CNT_W = $clog2(XLEN + 1);
    localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHU = 3'd2, OP_DIV = 3'd3,
                           OP_DIVU = 3'd4, OP_MOD = 3'd5, OP_MODU = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic                sign1_q, sign1_d, sign2_q, sign2_d, div0_q, div0_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d, mcand_q, mcand_d;
    logic [XLEN-1:0]     mplier_q, mplier_d, result_q, result_d;

    logic                in_signed, in_div, in_div0, neg1, neg2, q_div;
    logic [XLEN-1:0]     mag1, mag2, quot, rem_lo, res;
    logic [XLEN:0]       rem_sh, divisor;
    logic [2*XLEN-1:0]   add_sum, prod;

    assign in_ready_o  = (state_q == S_IDLE) && !rst_i;
    assign out_valid_o = (state_q == S_DONE);
    assign busy_o      = (state_q != S_IDLE);
    assign result_o    = result_q;
    assign tag_o       = tag_q;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        tag_d    = tag_q;
        sign1_d  = sign1_q;
        sign2_d  = sign2_q;
        div0_d   = div0_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        result_d = result_q;

        in_signed = (op_i == OP_MUL) || (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_MOD);
        in_div    = (op_i >= OP_DIV) && (op_i <= OP_MODU);
        in_div0   = in_div && (opd2_i == '0);
        neg1      = in_signed && opd1_i[XLEN-1];
        neg2      = in_signed && opd2_i[XLEN-1];
        mag1      = neg1 ? (~opd1_i + 1'b1) : opd1_i;
        mag2      = neg2 ? (~opd2_i + 1'b1) : opd2_i;
        q_div     = (op_q >= OP_DIV) && (op_q <= OP_MODU);

        // Divide state: acc holds the partial remainder, mplier shifts dividend out / quotient in.
        rem_sh  = {acc_q[XLEN-1:0], mplier_q[XLEN-1]};
        divisor = {1'b0, mcand_q[XLEN-1:0]};
        add_sum = '0;
        for (int j = 0; j < MUL_STEP; j++) begin
            if (mplier_q[j]) add_sum = add_sum + (mcand_q << j);
        end
        prod   = (sign1_q ^ sign2_q) ? -acc_q : acc_q;
        quot   = (sign1_q ^ sign2_q) ? -mplier_q : mplier_q;
        rem_lo = sign1_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        res    = '0;

        case (state_q)
            S_IDLE: begin
                if (in_valid_i && !flush_i) begin
                    op_d    = op_i;
                    tag_d   = tag_i;
                    sign1_d = neg1;
                    sign2_d = neg2;
                    div0_d  = in_div0;
                    acc_d   = '0;
                    if (in_div) begin
                        // Divide-by-zero keeps the raw dividend for the MOD/MODU result.
                        mplier_d = in_div0 ? opd1_i : mag1;
                        mcand_d  = {{XLEN{1'b0}}, mag2};
                        cnt_d    = CNT_W'(XLEN);
                    end else begin
                        mplier_d = mag2;
                        mcand_d  = {{XLEN{1'b0}}, mag1};
                        cnt_d    = CNT_W'(XLEN / MUL_STEP);
                    end
                    state_d = (in_div0 || op_i == 3'd7) ? S_FIX : S_CALC;
                end
            end
            S_CALC: begin
                if (q_div) begin
                    if (rem_sh >= divisor) begin
                        acc_d    = {{(XLEN-1){1'b0}}, rem_sh - divisor};
                        mplier_d = {mplier_q[XLEN-2:0], 1'b1};
                    end else begin
                        acc_d    = {{(XLEN-1){1'b0}}, rem_sh};
                        mplier_d = {mplier_q[XLEN-2:0], 1'b0};
                    end
                end else begin
                    acc_d    = acc_q + add_sum;
                    mcand_d  = mcand_q << MUL_STEP;
                    mplier_d = mplier_q >> MUL_STEP;
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            end
            S_FIX: begin
                case (op_q)
                    OP_MUL:                   res = prod[XLEN-1:0];
                    OP_MULH, OP_MULHU:        res = prod[2*XLEN-1:XLEN];
                    OP_DIV, OP_DIVU:          res = div0_q ? '1 : quot;
                    OP_MOD, OP_MODU:          res = div0_q ? mplier_q : rem_lo;
                    default:                  res = '0;
                endcase
                if (!flush_i) result_d = res;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (flush_i) state_d = S_IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            tag_q    <= '0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            div0_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            tag_q    <= tag_d;
            sign1_q  <= sign1_d;
            sign2_q  <= sign2_d;
            div0_q   <= div0_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            result_q <= result_d;
        end
    end
endmodule

// File: tb/tb_ex_mdu.sv
// Scoreboard bench for ex_mdu: a driver pushes expected {accept edge, latency, tag, result}
// into a queue; a monitor checks each presented result against the queue head.
module tb_ex_mdu;
    localparam int XLEN = 32;
    localparam int MUL_STEP = 2;
    localparam int TAG_W = 5;
    localparam int EW = 32 + 8 + TAG_W + XLEN;

    logic clk = 1'b0;
    logic rst_i = 1'b1, flush_i = 1'b0, in_valid_i = 1'b0, out_ready_i = 1'b0;
    logic [2:0] op_i = '0;
    logic [XLEN-1:0] opd1_i = '0, opd2_i = '0;
    logic [TAG_W-1:0] tag_i = '0;
    logic in_ready_o, out_valid_o, busy_o;
    logic [XLEN-1:0] result_o;
    logic [TAG_W-1:0] tag_o;

    logic [EW-1:0] exp_q[$];
    int vectors = 0, misses = 0, cyc = 0;
    bit lat_seen = 0, hold_rdy = 1;

    ex_mdu #(.XLEN(XLEN), .MUL_STEP(MUL_STEP), .TAG_W(TAG_W)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o), .op_i(op_i), .opd1_i(opd1_i), .opd2_i(opd2_i),
        .tag_i(tag_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .result_o(result_o), .tag_o(tag_o), .busy_o(busy_o));

    // clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(posedge clk) begin
        #1;
        if (!hold_rdy) out_ready_i = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            misses++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model straight from the op definitions, using wide integer arithmetic.
    function automatic logic [XLEN-1:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        longint unsigned ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a)); sb = longint'($signed(b));
        ua = 64'(a); ub = 64'(b);
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = ua * ub; return p[63:32]; end
            3'd3: begin if (b == 0) return '1; p = sa / sb; return p[31:0]; end
            3'd4: begin if (b == 0) return '1; p = ua / ub; return p[31:0]; end
            3'd5: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            3'd6: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
            default: return '0;
        endcase
    endfunction

    function automatic logic [7:0] latency(input logic [2:0] op, input logic [31:0] b);
        if (op == 3'd7 || (op >= 3'd3 && b == 0)) return 8'd2;
        if (op <= 3'd2) return 8'(XLEN / MUL_STEP + 2);
        return 8'(XLEN + 2);
    endfunction

    // driver: called at a negedge; holds in_valid until accepted
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tg);
        int g = 0;
        in_valid_i = 1'b1; op_i = op; opd1_i = a; opd2_i = b; tag_i = tg;
        while (!in_ready_o && g < 200) begin
            @(negedge clk); g++;
        end
        if (!in_ready_o) begin
            misses++;
            $display("FAIL accept_timeout: in_ready_o stuck low, op %0d", op);
        end else begin
            exp_q.push_back({32'(cyc + 1), latency(op, b), tg, model(op, a, b)});
        end
        @(negedge clk);
        in_valid_i = 1'b0; opd1_i = $urandom; opd2_i = $urandom; op_i = 3'($urandom);
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 3000) begin
            @(negedge clk); g++;
        end
        if (exp_q.size() != 0) begin
            misses++;
            $display("FAIL drain_timeout: %0d results outstanding", exp_q.size());
            exp_q.delete();
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // scoreboard monitor, sampling after inputs settle at the negedge
    always @(negedge clk) begin
        logic [EW-1:0] e;
        #1;
        if (!rst_i && out_valid_o) begin
            if (exp_q.size() == 0) begin
                chk("spurious_valid", 64'(out_valid_o), 64'd0);
            end else begin
                e = exp_q[0];
                if (!lat_seen) begin
                    lat_seen = 1;
                    chk("latency", 64'(cyc + 1) - 64'(e[EW-1 -: 32]), 64'(e[TAG_W+XLEN +: 8]));
                end
                chk("result", 64'(result_o), 64'(e[XLEN-1:0]));
                chk("tag", 64'(tag_o), 64'(e[XLEN +: TAG_W]));
                chk("busy_valid", 64'(busy_o), 64'd1);
                if (out_ready_i) begin
                    void'(exp_q.pop_front());
                    lat_seen = 0;
                end
            end
        end
    end

    initial begin
        int g;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready_o), 64'd0);
        chk("rst_outs", {30'd0, out_valid_o, busy_o, result_o}, 64'd0);
        chk("rst_tag", 64'(tag_o), 64'd0);
        rst_i = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready_o), 64'd1);

        // directed ops with random backpressure
        hold_rdy = 0;
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
        issue(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1);
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
        issue(3'd3, 32'hFFFF_FFF9, 32'd2, 5'd3);
        issue(3'd5, 32'hFFFF_FFF9, 32'd2, 5'd4);
        issue(3'd4, 32'd100, 32'd7, 5'd6);
        issue(3'd6, 32'd100, 32'd7, 5'd7);
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
        issue(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
        issue(3'd4, 32'd5, 32'd0, 5'd10);
        issue(3'd5, 32'h1234, 32'd0, 5'd11);
        issue(3'd7, 32'd9, 32'd9, 5'd12);
        drain();

        // backpressure: hold result, competing request must be ignored
        hold_rdy = 1; out_ready_i = 1'b0;
        issue(3'd0, 32'd11, 32'd13, 5'd21);
        g = 0;
        while (!out_valid_o && g < 100) begin
            @(negedge clk); g++;
        end
        for (int i = 0; i < 5; i++) begin
            in_valid_i = 1'b1; op_i = 3'd4; opd1_i = 32'd50; opd2_i = 32'd5; tag_i = 5'd30;
            chk("bp_valid", 64'(out_valid_o), 64'd1);
            chk("bp_in_ready", 64'(in_ready_o), 64'd0);
            @(negedge clk);
        end
        out_ready_i = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 64'(out_valid_o), 64'd0);
        chk("bp_release_ready", 64'(in_ready_o), 64'd1);
        issue(3'd4, 32'd50, 32'd5, 5'd30);
        drain();

        // flush mid-divide, then a fresh multiply
        issue(3'd3, 32'd1000, 32'd3, 5'd14);
        repeat (8) @(negedge clk);
        flush_i = 1'b1; exp_q.delete(); lat_seen = 0;
        @(negedge clk);
        flush_i = 1'b0;
        chk("flush_in_ready", 64'(in_ready_o), 64'd1);
        chk("flush_busy", 64'(busy_o), 64'd0);
        repeat (40) @(negedge clk);
        issue(3'd0, 32'd3, 32'd4, 5'd17);
        drain();

        // reset mid-calculation
        issue(3'd3, 32'd77777, 32'd5, 5'd19);
        repeat (5) @(negedge clk);
        rst_i = 1'b1; exp_q.delete(); lat_seen = 0;
        @(negedge clk);
        chk("midrst_outs", {30'd0, out_valid_o, busy_o, result_o}, 64'd0);
        chk("midrst_tag", 64'(tag_o), 64'd0);
        chk("midrst_in_ready", 64'(in_ready_o), 64'd0);
        rst_i = 1'b0;
        @(negedge clk);
        chk("midrst_release", 64'(in_ready_o), 64'd1);

        // randomized traffic
        hold_rdy = 0;
        for (int i = 0; i < 40; i++) begin
            issue(3'($urandom_range(0, 7)), pick(), pick(), TAG_W'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end
endmodule
